// File: rtl/dmem_responder_if.sv
// Request/response bundle between the memory stage and the data-memory responder.
interface dmem_responder_if;
    logic [63:0] address;
    logic        write_enable;
    logic        read_enable;
    logic [63:0] write_data;
    logic [3:0]  xfer_size;
    logic [63:0] read_data;
    logic        ready;
    logic        busy;
    logic        error;

    modport master (
        output address, write_enable, read_enable, write_data, xfer_size,
        input  read_data, ready, busy, error
    );

    modport slave (
        input  address, write_enable, read_enable, write_data, xfer_size,
        output read_data, ready, busy, error
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: byte-addressed little-endian array serving
// 64-bit and 8-bit loads/stores with a fixed latency, plus illegal-request flagging.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for read_enable/write_enable; request latched on accept
// BUSY   | access in flight, counter runs down; completes when counter is 0
// DONE   | one-cycle ready pulse, error valid; enables ignored
module dmem_responder #(
    parameter int DEPTH_BYTES = 1024,
    parameter int LATENCY     = 3
) (
    input logic              clk,
    input logic              reset,
    dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = $clog2(LATENCY) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           we_q, we_d;
    logic           re_q, re_d;
    logic [63:0]    wdata_q, wdata_d;
    logic           is64_q, is64_d;
    logic           illegal_q, illegal_d;
    logic [63:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic           commit_store;

    logic [7:0]     mem_q [DEPTH_BYTES] = '{default: 8'h00};

    logic           req_size64;
    logic           req_size8;
    logic           req_upper;
    logic           req_illegal;
    logic [63:0]    mem_rd;

    // Classify the incoming request. DEPTH_BYTES is a power of two >= 8, so an
    // aligned 64-bit access whose upper address bits are clear never crosses the end.
    always_comb begin
        req_size64  = (bus.xfer_size == 4'b1000);
        req_size8   = (bus.xfer_size == 4'b0001);
        req_upper   = |bus.address[63:AW];
        req_illegal = (bus.write_enable && bus.read_enable)
                    || !(req_size64 || req_size8)
                    || (req_size64 && (bus.address[2:0] != 3'b000))
                    || req_upper;
    end

    // Assemble load data from the latched address, little-endian.
    always_comb begin
        mem_rd = '0;
        if (is64_q) begin
            for (int i = 0; i < 8; i++) begin
                mem_rd[8*i +: 8] = mem_q[addr_q + AW'(i)];
            end
        end else begin
            mem_rd[7:0] = mem_q[addr_q];
        end
    end

    // Next-state and datapath update for the request FSM.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        re_d         = re_q;
        wdata_d      = wdata_q;
        is64_d       = is64_q;
        illegal_d    = illegal_q;
        rdata_d      = rdata_q;
        err_d        = err_q;
        commit_store = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.read_enable || bus.write_enable) begin
                    addr_d    = bus.address[AW-1:0];
                    we_d      = bus.write_enable;
                    re_d      = bus.read_enable;
                    wdata_d   = bus.write_data;
                    is64_d    = req_size64;
                    illegal_d = req_illegal;
                    cnt_d     = CW'(LATENCY - 1);
                    state_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = S_DONE;
                    if (illegal_q) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        if (re_q) rdata_d = mem_rd;
                        if (we_q) commit_store = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and request registers; reset aborts any in-flight access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            wdata_q   <= '0;
            is64_q    <= 1'b0;
            illegal_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            re_q      <= re_d;
            wdata_q   <= wdata_d;
            is64_q    <= is64_d;
            illegal_q <= illegal_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

    // Store commit on the completion edge; memory contents survive reset.
    always_ff @(posedge clk) begin
        if (commit_store) begin
            if (is64_q) begin
                for (int i = 0; i < 8; i++) begin
                    mem_q[addr_q + AW'(i)] <= wdata_q[8*i +: 8];
                end
            end else begin
                mem_q[addr_q] <= wdata_q[7:0];
            end
        end
    end

    assign bus.read_data = rdata_q;
    assign bus.ready     = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_BUSY);
    assign bus.error     = err_q;
endmodule
